// File: rtl/stream_downsize_if.sv
// rtl/stream_downsize_if.sv - wide-in / narrow-out stream bundle for stream_downsize
interface stream_downsize_if #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
);
  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] s_keep_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_downsize.sv
// rtl/stream_downsize.sv - wide-to-narrow stream converter emitting kept lanes in ascending order
// Optional STREAM_DOWNSIZE_PREFETCH_EN: reload on the edge the final lane drains (zero-bubble).
module stream_downsize #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  stream_downsize_if.slave bus
);
  localparam int IDX_W = $clog2(T_DATA_RATIO);

  typedef enum logic {EMPTY, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] rem_q, rem_d, rem_drained;
  logic                    last_q, last_d;
  logic [IDX_W-1:0]        sel_idx;
  logic                    found;
  logic                    one_left;
  logic                    s_hs, m_hs;

  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      if (!found && rem_q[i]) begin
        sel_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit; zero result means the current lane is the final one.
  assign rem_drained = rem_q & (rem_q - 1'b1);
  assign one_left    = (rem_q != '0) && (rem_drained == '0);

  assign bus.m_valid_o = (state_q == DRAIN);
  assign bus.m_data_o  = data_q[sel_idx];
  assign bus.m_last_o  = last_q && one_left;

  assign m_hs = bus.m_valid_o && bus.m_ready_i;
  assign s_hs = bus.s_valid_i && bus.s_ready_o;

`ifdef STREAM_DOWNSIZE_PREFETCH_EN
  assign bus.s_ready_o = (state_q == EMPTY) || (m_hs && one_left);
`else
  assign bus.s_ready_o = (state_q == EMPTY);
`endif

  always_comb begin
    rem_d  = rem_q;
    last_d = last_q;
    data_d = data_q;
    if (m_hs) begin
      rem_d = rem_drained;
    end
    if (s_hs) begin
      rem_d  = bus.s_keep_i;
      last_d = bus.s_last_i;
      data_d = bus.s_data_i;
    end
    state_d = (rem_d != '0) ? DRAIN : EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  // A last flag on an empty beat would be silently lost.
  assert property (@(posedge clk_i) disable iff (rst_i)
    s_hs |-> (bus.s_keep_i != '0 || !bus.s_last_i));
endmodule

// File: tb/tb_stream_downsize.sv
// tb/tb_stream_downsize.sv - randomized + directed bench for stream_downsize with lane-queue model
module tb_stream_downsize;
  localparam int W = 8;
  localparam int R = 4;
`ifdef STREAM_DOWNSIZE_PREFETCH_EN
  localparam int T4_SPAN = 8;
`else
  localparam int T4_SPAN = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [W:0] q [$];
  logic       prev_stall = 1'b0;
  logic [W:0] prev_beat = '0;
  logic       rand_done = 1'b0;

  always #5 clk = ~clk;

  stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every accepted wide beat expands to its kept lanes, last tagged on the highest kept lane.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.m_valid_o, 1);
        check("hold_beat", {bus.m_last_o, bus.m_data_o}, prev_beat);
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        check("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) check("beat", {bus.m_last_o, bus.m_data_o}, q.pop_front());
      end
      prev_stall = bus.m_valid_o && !bus.m_ready_i;
      prev_beat  = {bus.m_last_o, bus.m_data_o};
      if (bus.s_valid_i && bus.s_ready_o) begin
        int hi;
        hi = -1;
        for (int i = 0; i < R; i++) if (bus.s_keep_i[i]) hi = i;
        for (int i = 0; i < R; i++)
          if (bus.s_keep_i[i]) q.push_back({bus.s_last_i && (i == hi), bus.s_data_i[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [R*W-1:0] d, input logic [R-1:0] k, input logic l);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < R; i++) bus.s_data_i[i] = d[i*W +: W];
    bus.s_keep_i  = k;
    bus.s_last_i  = l;
    bus.s_valid_i = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = bus.s_ready_o;
      tick();
    end
    bus.s_valid_i = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 100 && !idle; n++) begin
      if (!bus.m_valid_o) idle = 1'b1;
      else tick();
    end
    check(tag, idle, 1);
  endtask

  initial begin
    logic [W-1:0] t1_exp [R];
    int n_out, first, lastc;
    logic b2acc;

    for (int i = 0; i < R; i++) bus.s_data_i[i] = '0;
    bus.s_keep_i = '0; bus.s_last_i = 1'b0; bus.s_valid_i = 1'b0; bus.m_ready_i = 1'b0;
    #1;
    check("rst_valid", bus.m_valid_o, 0);
    check("rst_last", bus.m_last_o, 0);
    tick(); tick();
    rst = 1'b0;
    check("rst_sready", bus.s_ready_o, 1);
    check("rst_valid_after", bus.m_valid_o, 0);

    // Full beat, lane 0 first, last on lane 3
    bus.m_ready_i = 1'b1;
    t1_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 4'b1111, 1'b1);
    for (int i = 0; i < R; i++) begin
      check("t1_valid", bus.m_valid_o, 1);
      check("t1_data", bus.m_data_o, t1_exp[i]);
      check("t1_last", bus.m_last_o, i == R - 1);
      tick();
    end
    check("t1_idle", bus.m_valid_o, 0);

    // Holes are skipped
    send({8'h44, 8'h33, 8'h22, 8'h11}, 4'b1010, 1'b1);
    check("t2_data0", bus.m_data_o, 8'h22);
    check("t2_last0", bus.m_last_o, 0);
    tick();
    check("t2_data1", bus.m_data_o, 8'h44);
    check("t2_last1", bus.m_last_o, 1);
    tick();
    check("t2_idle", bus.m_valid_o, 0);

    // Backpressure on lane 1
    send({8'h88, 8'h77, 8'h66, 8'h55}, 4'b0111, 1'b0);
    tick();
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", bus.m_valid_o, 1);
      check("t3_data", bus.m_data_o, 8'h66);
      check("t3_sready", bus.s_ready_o, 0);
      tick();
    end
    bus.m_ready_i = 1'b1;
    tick();
    check("t3_next", bus.m_data_o, 8'h77);
    wait_idle("t3_drain");

    // Back-to-back full beats
    send({8'h04, 8'h03, 8'h02, 8'h01}, 4'b1111, 1'b0);
    for (int i = 0; i < R; i++) bus.s_data_i[i] = W'(8'h10 + i);
    bus.s_keep_i = 4'b1111; bus.s_last_i = 1'b1; bus.s_valid_i = 1'b1;
    n_out = 0; first = -1; lastc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.m_valid_o && bus.m_ready_i) begin
        n_out++;
        if (first < 0) first = c;
        lastc = c;
      end
      b2acc = bus.s_valid_i && bus.s_ready_o;
      tick();
      if (b2acc) bus.s_valid_i = 1'b0;
    end
    check("t4_beats", n_out, 8);
    check("t4_span", lastc - first + 1, T4_SPAN);

    // Empty keep
    send({8'hFF, 8'hEE, 8'hDD, 8'hCC}, 4'b0000, 1'b0);
    check("t5_valid", bus.m_valid_o, 0);
    check("t5_sready", bus.s_ready_o, 1);
    tick();
    check("t5_valid_next", bus.m_valid_o, 0);

    // Async reset mid-drain
    send({8'h9D, 8'h9C, 8'h9B, 8'h9A}, 4'b1111, 1'b1);
    tick(); tick();
    check("t6_pending", bus.m_data_o, 8'h9C);
    #2 rst = 1'b1;
    #1;
    check("t6_valid_drop", bus.m_valid_o, 0);
    check("t6_last_drop", bus.m_last_o, 0);
    tick();
    rst = 1'b0;
    check("t6_sready", bus.s_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_stale", bus.m_valid_o, 0);
      tick();
    end

    // Random traffic with random backpressure
    fork
      begin
        for (int b = 0; b < 200; b++) begin
          logic [R*W-1:0] d;
          logic [R-1:0]   k;
          logic           l;
          d = {$urandom, $urandom} ;
          k = R'($urandom);
          l = ($urandom_range(0, 1) == 1) && (k != '0);
          send(d, k, l);
          repeat ($urandom_range(0, 2)) tick();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.m_ready_i = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    bus.m_ready_i = 1'b1;
    wait_idle("rand_drain");
    tick();
    check("model_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
